// File: rtl/project_primitive_to_viewport_if.sv
// Primitive-in / screen-space-out bus between vertex fetch, the projector and raster setup.
// Latency: none, plain wires.
// Backpressure: valid_in/ready_out upstream, valid_out/ready_in downstream.
interface project_primitive_to_viewport_if #(
  parameter int NUM_VERTS                 = 3,
  parameter int C_WIDTH                   = 18,
  parameter int P_WIDTH                   = 16,
  parameter int V_WIDTH                   = 16,
  parameter int VIEWPORT_W_POSITION_WIDTH = 20,
  parameter int VIEWPORT_H_POSITION_WIDTH = 18,
  parameter int ZWIDTH                    = 16
);
  // upstream side: one primitive plus the camera it is seen from
  logic                        valid_in;
  logic                        ready_out;
  logic signed [P_WIDTH-1:0]   P [NUM_VERTS][3];
  logic signed [C_WIDTH-1:0]   C [3];
  logic signed [V_WIDTH-1:0]   u [3];
  logic signed [V_WIDTH-1:0]   v [3];
  logic signed [V_WIDTH-1:0]   n [3];

  // downstream side: one screen-space beat per kept primitive
  logic                                 valid_out;
  logic                                 ready_in;
  logic [VIEWPORT_W_POSITION_WIDTH-1:0] viewport_x_position [NUM_VERTS];
  logic [VIEWPORT_H_POSITION_WIDTH-1:0] viewport_y_position [NUM_VERTS];
  logic [ZWIDTH-1:0]                    z_depth [NUM_VERTS];
  logic                                 short_circuit;

  // master: the environment around the projector (fetch + raster setup)
  modport master (
    output valid_in, P, C, u, v, n, ready_in,
    input  ready_out, valid_out, viewport_x_position, viewport_y_position, z_depth, short_circuit
  );

  // slave: the projector itself
  modport slave (
    input  valid_in, P, C, u, v, n, ready_in,
    output ready_out, valid_out, viewport_x_position, viewport_y_position, z_depth, short_circuit
  );
endinterface

// File: rtl/project_primitive_to_viewport.sv
// Projects NUM_VERTS camera-relative vertices to viewport coordinates through one shared dot/divide path.
// Latency: per vertex LOAD + DOT + (NW-cycle divide unless near-rejected) + NEXT, then DECIDE; one primitive in flight.
// Backpressure: ready_out low from acceptance until IDLE; result held in HOLD until ready_in.
module project_primitive_to_viewport #(
  parameter int NUM_VERTS                 = 3,
  parameter int C_WIDTH                   = 18,
  parameter int P_WIDTH                   = 16,
  parameter int V_WIDTH                   = 16,
  parameter int FRAC_BITS                 = 14,
  parameter int FOCAL_SHIFT               = 8,
  parameter int NEAR_Z                    = 1,
  parameter int VW_OVER_TWO               = 320,
  parameter int VH_OVER_TWO               = 240,
  parameter int VIEWPORT_W_POSITION_WIDTH = 20,
  parameter int VIEWPORT_H_POSITION_WIDTH = 18,
  parameter int ZWIDTH                    = 16,
  parameter int CULL_ANY                  = 1
) (
  input  logic clk_in,
  input  logic rst_in,
  project_primitive_to_viewport_if.slave bus
);

  // camera-relative position, single product, three-term dot sum
  localparam int PCW = C_WIDTH + 1;
  localparam int PRW = PCW + V_WIDTH;
  localparam int SW  = PRW + 2;
  // dividend after focal scaling, and signed quotient
  localparam int NW  = SW + FOCAL_SHIFT;
  localparam int QW  = NW + 1;
  localparam int KW  = (NUM_VERTS > 1) ? $clog2(NUM_VERTS) : 1;
  localparam int CW  = $clog2(NW) + 1;

  localparam logic signed [QW-1:0] XMAX = QW'(VW_OVER_TWO);
  localparam logic signed [QW-1:0] XMIN = -XMAX;
  localparam logic signed [QW-1:0] XTOP = XMAX - QW'(1);
  localparam logic signed [QW-1:0] YMAX = QW'(VH_OVER_TWO);
  localparam logic signed [QW-1:0] YMIN = -YMAX;
  localparam logic signed [QW-1:0] YTOP = YMAX - QW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DOT, S_DIV, S_NEXT, S_DECIDE, S_HOLD
  } state_t;

  // control state (reset)
  state_t                               state_q, state_d;
  logic [KW-1:0]                        k_q, k_d;
  logic                                 ready_q, ready_d;
  logic                                 valid_q, valid_d;
  logic                                 sc_q, sc_d;
  logic [NUM_VERTS-1:0]                 near_q, near_d;
  logic [NUM_VERTS-1:0]                 oob_q, oob_d;
  logic [VIEWPORT_W_POSITION_WIDTH-1:0] x_q [NUM_VERTS];
  logic [VIEWPORT_W_POSITION_WIDTH-1:0] x_d [NUM_VERTS];
  logic [VIEWPORT_H_POSITION_WIDTH-1:0] y_q [NUM_VERTS];
  logic [VIEWPORT_H_POSITION_WIDTH-1:0] y_d [NUM_VERTS];
  logic [ZWIDTH-1:0]                    z_q [NUM_VERTS];
  logic [ZWIDTH-1:0]                    z_d [NUM_VERTS];

  // datapath state (no reset needed, always written before use)
  logic signed [P_WIDTH-1:0] p_q [NUM_VERTS][3];
  logic signed [P_WIDTH-1:0] p_d [NUM_VERTS][3];
  logic signed [C_WIDTH-1:0] c_q [3];
  logic signed [C_WIDTH-1:0] c_d [3];
  logic signed [V_WIDTH-1:0] u_q [3];
  logic signed [V_WIDTH-1:0] u_d [3];
  logic signed [V_WIDTH-1:0] v_q [3];
  logic signed [V_WIDTH-1:0] v_d [3];
  logic signed [V_WIDTH-1:0] n_q [3];
  logic signed [V_WIDTH-1:0] n_d [3];
  logic signed [PCW-1:0]     pc_q [3];
  logic signed [PCW-1:0]     pc_d [3];
  logic signed [SW-1:0]      dz_q, dz_d;
  logic [SW-1:0]             remx_q, remx_d, remy_q, remy_d;
  logic [NW-1:0]             quox_q, quox_d, quoy_q, quoy_d;
  logic                      negx_q, negx_d, negy_q, negy_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  // combinational datapath
  logic signed [SW-1:0] sum_x, sum_y, sum_z;
  logic signed [SW-1:0] dot_x, dot_y, dot_z;
  logic signed [NW-1:0] num_x, num_y;
  logic [NW-1:0]        mag_x, mag_y;
  logic signed [QW-1:0] qx, qy, cx, cy;
  logic                 in_x, in_y;
  logic                 culled;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  // The dividend magnitude lives in quo and is replaced by quotient bits from the LSB side.
  function automatic logic [SW+NW-1:0] div_step(input logic [SW-1:0] rem,
                                                input logic [NW-1:0] quo,
                                                input logic [SW-1:0] d);
    logic [SW:0]   r;
    logic [NW-1:0] q;
    r = {rem, quo[NW-1]};
    q = {quo[NW-2:0], 1'b0};
    if (r >= {1'b0, d}) begin
      r    = r - {1'b0, d};
      q[0] = 1'b1;
    end
    return {r[SW-1:0], q};
  endfunction

  // Dot products, divider seed values, and bounds/clamp of the finished quotient.
  always_comb begin
    sum_x = '0;
    sum_y = '0;
    sum_z = '0;
    for (int i = 0; i < 3; i++) begin
      sum_x = sum_x + SW'(PRW'(pc_q[i]) * PRW'(u_q[i]));
      sum_y = sum_y + SW'(PRW'(pc_q[i]) * PRW'(v_q[i]));
      sum_z = sum_z + SW'(PRW'(pc_q[i]) * PRW'(n_q[i]));
    end
    dot_x = sum_x >>> FRAC_BITS;
    dot_y = sum_y >>> FRAC_BITS;
    dot_z = sum_z >>> FRAC_BITS;
    num_x = NW'(dot_x) <<< FOCAL_SHIFT;
    num_y = NW'(dot_y) <<< FOCAL_SHIFT;
    mag_x = num_x[NW-1] ? $unsigned(-num_x) : $unsigned(num_x);
    mag_y = num_y[NW-1] ? $unsigned(-num_y) : $unsigned(num_y);
    // divide ran on magnitudes; restoring the sign gives truncation toward zero
    qx = negx_q ? -$signed({1'b0, quox_q}) : $signed({1'b0, quox_q});
    qy = negy_q ? -$signed({1'b0, quoy_q}) : $signed({1'b0, quoy_q});
    in_x = (qx > XMIN) && (qx < XMAX);
    in_y = (qy > YMIN) && (qy < YMAX);
    cx = qx;
    if (qx < XMIN)      cx = XMIN;
    else if (qx > XTOP) cx = XTOP;
    cy = qy;
    if (qy < YMIN)      cy = YMIN;
    else if (qy > YTOP) cy = YTOP;
  end

  // A near-plane vertex always culls; otherwise the bounds policy decides.
  assign culled = (|near_q) || ((CULL_ANY != 0) ? (|oob_q) : (&oob_q));

  // Sequencer: walks each vertex through load, dot, divide and store, then decides.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ready_d = ready_q;
    valid_d = valid_q;
    sc_d    = 1'b0;
    near_d  = near_q;
    oob_d   = oob_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    p_d     = p_q;
    c_d     = c_q;
    u_d     = u_q;
    v_d     = v_q;
    n_d     = n_q;
    pc_d    = pc_q;
    dz_d    = dz_q;
    remx_d  = remx_q;
    remy_d  = remy_q;
    quox_d  = quox_q;
    quoy_d  = quoy_q;
    negx_d  = negx_q;
    negy_d  = negy_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (bus.valid_in && ready_q) begin
          p_d     = bus.P;
          c_d     = bus.C;
          u_d     = bus.u;
          v_d     = bus.v;
          n_d     = bus.n;
          k_d     = '0;
          near_d  = '0;
          oob_d   = '0;
          ready_d = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        for (int i = 0; i < 3; i++) begin
          pc_d[i] = PCW'(p_q[k_q][i]) - PCW'(c_q[i]);
        end
        state_d = S_DOT;
      end
      S_DOT: begin
        dz_d     = dot_z;
        z_d[k_q] = dot_z[ZWIDTH-1:0];
        if (dot_z < SW'(NEAR_Z)) begin
          // behind or on the near plane: never reaches the divider
          near_d[k_q] = 1'b1;
          state_d     = S_NEXT;
        end else begin
          quox_d  = mag_x;
          quoy_d  = mag_y;
          negx_d  = num_x[NW-1];
          negy_d  = num_y[NW-1];
          remx_d  = '0;
          remy_d  = '0;
          cnt_d   = CW'(NW - 1);
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        // x and y share the step counter, so both finish on the same cycle
        {remx_d, quox_d} = div_step(remx_q, quox_q, $unsigned(dz_q));
        {remy_d, quoy_d} = div_step(remy_q, quoy_q, $unsigned(dz_q));
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (!near_q[k_q]) begin
          x_d[k_q]   = VIEWPORT_W_POSITION_WIDTH'(cx + XMAX);
          y_d[k_q]   = VIEWPORT_H_POSITION_WIDTH'(cy + YMAX);
          oob_d[k_q] = !(in_x && in_y);
        end
        if (k_q == KW'(NUM_VERTS - 1)) begin
          state_d = S_DECIDE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_DECIDE: begin
        if (culled) begin
          sc_d    = 1'b1;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (valid_q && bus.ready_in) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

  // Control and visible-output registers; reset aborts any primitive in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      sc_q    <= 1'b0;
      near_q  <= '0;
      oob_q   <= '0;
      for (int i = 0; i < NUM_VERTS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        z_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      sc_q    <= sc_d;
      near_q  <= near_d;
      oob_q   <= oob_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  // Datapath registers: latched primitive, camera-relative vertex and divider state.
  always_ff @(posedge clk_in) begin
    p_q    <= p_d;
    c_q    <= c_d;
    u_q    <= u_d;
    v_q    <= v_d;
    n_q    <= n_d;
    pc_q   <= pc_d;
    dz_q   <= dz_d;
    remx_q <= remx_d;
    remy_q <= remy_d;
    quox_q <= quox_d;
    quoy_q <= quoy_d;
    negx_q <= negx_d;
    negy_q <= negy_d;
    cnt_q  <= cnt_d;
  end

  assign bus.ready_out           = ready_q;
  assign bus.valid_out           = valid_q;
  assign bus.short_circuit       = sc_q;
  assign bus.viewport_x_position = x_q;
  assign bus.viewport_y_position = y_q;
  assign bus.z_depth             = z_q;

endmodule
